// File: rtl/motor_apb_pkg.sv
// Shared types and constants for the motor APB initiator.
// It also holds the motor_mmio_handler register map.
package motor_apb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 32;
  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam int unsigned MOTOR_X_ADDR = 1;
  localparam int unsigned MOTOR_Y_ADDR = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWaitIrq,
    StSetup,
    StAccess,
    StResp
  } apb_state_e;

  function automatic logic is_motor_reg(input logic [31:0] addr);
    return (addr == 32'(MOTOR_X_ADDR)) || (addr == 32'(MOTOR_Y_ADDR));
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector on the handler's fabint line.
// fabint is registered every cycle; the edge indication compares the live level with the previous one.
module irq_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_fabint,
  output logic o_rise
);

  logic r_fabint_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fabint_q <= 1'b0;
    end else begin
      r_fabint_q <= i_fabint;
    end
  end

  assign o_rise = i_fabint & ~r_fabint_q;

endmodule

// File: rtl/motor_apb_initiator.sv
// APB initiator for motor_mmio_handler: turns a cmd/rsp handshake into single APB transfers.
// Each transfer is optionally gated on a fabint rising edge. All outputs come straight from flops.
module motor_apb_initiator
  import motor_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic              i_cmd_wait_irq,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_rsp_timeout,
  input  logic              i_fabint,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e        r_state;
  apb_state_e        w_state_d;
  logic              r_cmd_ready;
  logic              w_cmd_ready_d;
  logic              r_psel;
  logic              w_psel_d;
  logic              r_penable;
  logic              w_penable_d;
  logic              r_pwrite;
  logic              w_pwrite_d;
  logic [ADDR_W-1:0] r_paddr;
  logic [ADDR_W-1:0] w_paddr_d;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] w_pwdata_d;
  logic              r_rsp_valid;
  logic              w_rsp_valid_d;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [DATA_W-1:0] w_rsp_rdata_d;
  logic              r_rsp_err;
  logic              w_rsp_err_d;
  logic              r_rsp_timeout;
  logic              w_rsp_timeout_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_d;
  logic              w_irq_rise;

  irq_edge_detect u_irq_edge (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_fabint (i_fabint),
    .o_rise   (w_irq_rise)
  );

  always_comb begin
    w_state_d       = r_state;
    w_psel_d        = 1'b0;
    w_penable_d     = 1'b0;
    w_pwrite_d      = r_pwrite;
    w_paddr_d       = r_paddr;
    w_pwdata_d      = r_pwdata;
    w_rsp_valid_d   = 1'b0;
    w_rsp_rdata_d   = r_rsp_rdata;
    w_rsp_err_d     = r_rsp_err;
    w_rsp_timeout_d = r_rsp_timeout;
    w_cnt_d         = r_cnt;

    unique case (r_state)
      StIdle: begin
        // The bus-side address/data flops double as the command latch; psel stays low until SETUP.
        if (i_cmd_valid) begin
          w_pwrite_d = i_cmd_write;
          w_paddr_d  = i_cmd_addr;
          w_pwdata_d = i_cmd_wdata;
          if (i_cmd_wait_irq) begin
            w_state_d = StWaitIrq;
          end else begin
            w_state_d = StSetup;
            w_psel_d  = 1'b1;
          end
        end
      end
      StWaitIrq: begin
        if (w_irq_rise) begin
          w_state_d = StSetup;
          w_psel_d  = 1'b1;
        end
      end
      StSetup: begin
        w_state_d   = StAccess;
        w_psel_d    = 1'b1;
        w_penable_d = 1'b1;
      end
      StAccess: begin
        w_psel_d    = 1'b1;
        w_penable_d = 1'b1;
        if (!i_pready) begin
          w_cnt_d = r_cnt + 1'b1;
        end
        // A ready slave takes priority over a timeout expiring in the same cycle.
        if (i_pready) begin
          w_state_d       = StResp;
          w_psel_d        = 1'b0;
          w_penable_d     = 1'b0;
          w_rsp_valid_d   = 1'b1;
          w_rsp_rdata_d   = r_pwrite ? '0 : i_prdata;
          w_rsp_err_d     = i_pslverr;
          w_rsp_timeout_d = 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_d       = StResp;
          w_psel_d        = 1'b0;
          w_penable_d     = 1'b0;
          w_rsp_valid_d   = 1'b1;
          w_rsp_rdata_d   = '0;
          w_rsp_err_d     = 1'b1;
          w_rsp_timeout_d = 1'b1;
        end
      end
      StResp: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase

    w_cmd_ready_d = (w_state_d == StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_cmd_ready   <= 1'b1;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_d;
      r_cmd_ready   <= w_cmd_ready_d;
      r_psel        <= w_psel_d;
      r_penable     <= w_penable_d;
      r_pwrite      <= w_pwrite_d;
      r_paddr       <= w_paddr_d;
      r_pwdata      <= w_pwdata_d;
      r_rsp_valid   <= w_rsp_valid_d;
      r_rsp_rdata   <= w_rsp_rdata_d;
      r_rsp_err     <= w_rsp_err_d;
      r_rsp_timeout <= w_rsp_timeout_d;
      r_cnt         <= w_cnt_d;
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_psel        = r_psel;
  assign o_penable     = r_penable;
  assign o_pwrite      = r_pwrite;
  assign o_paddr       = r_paddr;
  assign o_pwdata      = r_pwdata;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_err     = r_rsp_err;
  assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: doc/motor_apb_initiator.md
Name: motor_apb_initiator

Overview:
APB initiator that drives the motor MMIO handler's slave port (psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr) from a simple command/response handshake. Optionally holds each command until a rising edge on the handler's fabint interrupt, then issues it. Sits between the firmware/sequencer side and motor_mmio_handler, and replaces the hand-driven bus stimulus used in simulation today.

Parameters:
ADDR_W, 32, paddr / cmd_addr width
DATA_W, 32, pwdata / prdata / cmd_wdata width
TIMEOUT, 255, max ACCESS cycles waiting for pready before abort; must be at least 1; counter width $clog2(TIMEOUT+1)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  initiator can accept a command
cmd_write  in  1  1=write, 0=read
cmd_wait_irq  in  1  1=hold command until fabint rising edge
cmd_addr  in  ADDR_W  target register address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  pslverr or timeout
rsp_timeout  out  1  transfer aborted by timeout
fabint  in  1  interrupt from motor_mmio_handler
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Interface decided: single clock clk; reset synchronous, active-high.
- All outputs are registered. Reset values: state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, fabint_q=0, timeout counter=0. cmd_ready=1 in the first cycle after reset.
- cmd_ready = (state==IDLE). A command is accepted when cmd_valid && cmd_ready. On acceptance, write, addr, wdata and wait_irq are latched.
- FSM states: IDLE, WAIT_IRQ, SETUP, ACCESS, RESP.
  - IDLE: on accept, go to WAIT_IRQ if wait_irq=1, else to SETUP.
  - WAIT_IRQ: edge = fabint && !fabint_q. fabint_q is updated every cycle. Only edges seen while in WAIT_IRQ count; edges in earlier cycles are ignored and not queued. On edge, go to SETUP. There is no timeout in this state.
  - SETUP: psel=1, penable=0, paddr/pwrite/pwdata = latched values. Lasts one cycle, then ACCESS.
  - ACCESS: psel=1, penable=1. Address, data and direction are held stable. The counter increments each cycle in which pready=0.
    - If pready=1: rsp_rdata = write ? 0 : prdata, rsp_err = pslverr, rsp_timeout = 0, go to RESP.
    - Else if counter == TIMEOUT-1: rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, go to RESP.
    - If pready and timeout occur in the same cycle, pready wins.
  - RESP: psel=0, penable=0, rsp_valid=1 for exactly one cycle, counter cleared, then IDLE. rsp_* data holds until the next response.
- Latency, no wait_irq, zero-wait slave: accept at cycle 0; SETUP at cycle 1; ACCESS at cycle 2; rsp_valid at cycle 3; cmd_ready=1 at cycle 4.
- A new command can be accepted every 4 cycles minimum.
- psel drops between transfers; back-to-back ACCESS without SETUP is not allowed.
- Reset mid-transfer: reset wins in any state. Bus returns to idle the next cycle with no response. The in-flight command is dropped.
- fabint level held high does not retrigger; a new 0→1 transition is required.

Decomposition:
- Package motor_apb_pkg:
  - state enum (IDLE, WAIT_IRQ, SETUP, ACCESS, RESP)
  - handler register address constants: MOTOR_X_ADDR=1, MOTOR_Y_ADDR=4
  - ADDR_W/DATA_W defaults
- One sub-module: irq_edge_detect (registered rising-edge detector on fabint, synchronous reset).

Test Plan:
- Write, no wait: cmd addr=1 data=5, pready tied 1 → SETUP at cycle 1 (psel=1, penable=0, paddr=1, pwdata=5, pwrite=1); ACCESS at cycle 2; rsp_valid at cycle 3 with err=0, rdata=0.
- Read with 3 wait states: addr=4, prdata=0x1234 when pready rises at the 4th ACCESS cycle → paddr stable throughout, rsp_rdata=0x1234, rsp_err=0.
- Wait-irq sequence: 4 commands alternating addr 1/4, data 6..9, fabint pulsed every 20 cycles → each SETUP occurs 1 cycle after its fabint edge; fabint held high does not launch the next command.
- Errors: pslverr=1 with pready → rsp_err=1, rsp_timeout=0. With TIMEOUT=8 and pready=0 → rsp_timeout=1, rsp_err=1 after 8 ACCESS cycles; psel=0 the following cycle.
- Reset mid-ACCESS: assert reset for 1 cycle → next cycle psel=0, penable=0, no rsp_valid, cmd_ready=1.
- Boundary: pready=1 in the same cycle the counter hits TIMEOUT-1 → normal response, rsp_timeout=0.
